// File: rtl/key_cond_pkg.sv
// Shared types and constants for the key input conditioner: debounce state
// encoding and the saturating glitch counter helper.
package key_cond_pkg;

    typedef enum logic [1:0] {
        LOW      = 2'b00,
        RISE_CHK = 2'b01,
        HIGH     = 2'b10,
        FALL_CHK = 2'b11
    } key_state_e;

    localparam int GLITCH_W = 8;
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = 8'd255;

    // Clear has priority over an increment; the count holds at GLITCH_MAX.
    function automatic logic [GLITCH_W-1:0] glitch_next(
        input logic [GLITCH_W-1:0] cur,
        input logic                inc,
        input logic                clr
    );
        logic [GLITCH_W-1:0] nxt;
        if (clr) begin
            nxt = {GLITCH_W{1'b0}};
        end else if (inc && (cur != GLITCH_MAX)) begin
            nxt = cur + 8'd1;
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for a single asynchronous bit; all stages clear to 0
// on reset so a raw input held high at release looks like a fresh edge.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw bit one stage deeper each cycle.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Synchroniser stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{1'b0}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/key_conditioner.sv
// Synchronises and debounces a bouncing contact input into a clean level A,
// with one-cycle edge pulses and a saturating count of rejected bounces.
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                key_raw,
    input  logic                glitch_clr,
    output logic                A,
    output logic                a_rise,
    output logic                a_fall,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("key_conditioner: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce_cycles
        $error("key_conditioner: DEBOUNCE_CYCLES must be >= 2");
    end

    logic                key_s;
    logic                glitch_inc_s;
    key_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                a_q, a_d;
    logic                a_rise_q, a_rise_d;
    logic                a_fall_q, a_fall_d;
    logic [GLITCH_W-1:0] glitch_q, glitch_d;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_key_sync (
        .clk   (Clock),
        .rst_n (Reset),
        .d     (key_raw),
        .q     (key_s)
    );

    // Debounce FSM: a level change is accepted only after DEBOUNCE_CYCLES
    // consecutive agreeing samples; the first sample is the one that leaves LOW/HIGH.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        a_rise_d     = 1'b0;
        a_fall_d     = 1'b0;
        glitch_inc_s = 1'b0;
        case (state_q)
            LOW: begin
                if (key_s) begin
                    state_d = RISE_CHK;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = LOW;
                end
            end
            RISE_CHK: begin
                if (!key_s) begin
                    state_d      = LOW;
                    cnt_d        = {CNT_W{1'b0}};
                    glitch_inc_s = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = HIGH;
                    cnt_d    = {CNT_W{1'b0}};
                    a_d      = 1'b1;
                    a_rise_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HIGH: begin
                if (!key_s) begin
                    state_d = FALL_CHK;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = HIGH;
                end
            end
            FALL_CHK: begin
                if (key_s) begin
                    state_d      = HIGH;
                    cnt_d        = {CNT_W{1'b0}};
                    glitch_inc_s = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = LOW;
                    cnt_d    = {CNT_W{1'b0}};
                    a_d      = 1'b0;
                    a_fall_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = {CNT_W{1'b0}};
                a_d     = 1'b0;
            end
        endcase
        glitch_d = glitch_next(glitch_q, glitch_inc_s, glitch_clr);
    end

    // State, counters and all outputs are registered.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= LOW;
            cnt_q    <= {CNT_W{1'b0}};
            a_q      <= 1'b0;
            a_rise_q <= 1'b0;
            a_fall_q <= 1'b0;
            glitch_q <= {GLITCH_W{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            a_rise_q <= a_rise_d;
            a_fall_q <= a_fall_d;
            glitch_q <= glitch_d;
        end
    end

    assign A          = a_q;
    assign a_rise     = a_rise_q;
    assign a_fall     = a_fall_q;
    assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4
// (accept latency 5 edges): per-cycle vector table plus reset/saturation sequences.
module tb_key_conditioner;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       key_raw;
    logic       glitch_clr;
    logic       A;
    logic       a_rise;
    logic       a_fall;
    logic [7:0] glitch_cnt;

    int errors = 0;
    int checks = 0;
    int rise_seen = 0;
    int fall_seen = 0;
    int both_seen = 0;

    typedef struct {
        logic       raw;
        logic       clr;
        logic       a;
        logic       rise;
        logic       fall;
        logic [7:0] g;
    } vec_t;

    typedef struct {
        logic [10:0] outs;
        string       name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    always #5 Clock = ~Clock;

    key_conditioner #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .key_raw    (key_raw),
        .glitch_clr (glitch_clr),
        .A          (A),
        .a_rise     (a_rise),
        .a_fall     (a_fall),
        .glitch_cnt (glitch_cnt)
    );

    always @(negedge Clock) begin
        if (a_rise) rise_seen++;
        if (a_fall) fall_seen++;
        if (a_rise && a_fall) both_seen++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic raw, input logic clr);
        key_raw    = raw;
        glitch_clr = clr;
        @(posedge Clock);
        #1;
    endtask

    // Expected outputs go into the scoreboard with the stimulus and come out after the edge.
    task automatic apply(input vec_t v, input string name);
        exp_t e;
        e.outs = {v.a, v.rise, v.fall, v.g};
        e.name = name;
        sb.push_back(e);
        drive(v.raw, v.clr);
        e = sb.pop_front();
        check(e.name, {21'd0, A, a_rise, a_fall, glitch_cnt}, {21'd0, e.outs});
    endtask

    task automatic add(input logic raw, input logic clr, input logic a,
                       input logic r, input logic f, input logic [7:0] g);
        vec_t v;
        v.raw = raw; v.clr = clr; v.a = a; v.rise = r; v.fall = f; v.g = g;
        vecs.push_back(v);
    endtask

    initial begin
        int r0;
        int f0;
        vec_t v;

        // Clean press: A and a_rise after the 6th edge (e0+5).
        for (int j = 0; j < 8; j++) add(1'b1, 1'b0, j >= 5, j == 5, 1'b0, 8'd0);
        // Clean release.
        for (int j = 0; j < 8; j++) add(1'b0, 1'b0, j < 5, 1'b0, j == 5, 8'd0);
        // Bounce: high 3, low 2, high held; 3 samples is one short of acceptance.
        for (int j = 0; j < 13; j++)
            add((j < 3) || (j >= 5), 1'b0, j >= 10, j == 10, 1'b0, (j >= 5) ? 8'd1 : 8'd0);
        // Release bounce from HIGH: low 2 then high, rejected in FALL_CHK.
        for (int j = 0; j < 8; j++) add(j >= 2, 1'b0, 1'b1, 1'b0, 1'b0, (j >= 4) ? 8'd2 : 8'd1);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);

        Reset      = 1'b0;
        key_raw    = 1'b0;
        glitch_clr = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        check("reset_A", A, 0);
        check("reset_a_rise", a_rise, 0);
        check("reset_a_fall", a_fall, 0);
        check("reset_glitch_cnt", glitch_cnt, 0);
        @(negedge Clock);
        Reset = 1'b1;

        r0 = rise_seen;
        f0 = fall_seen;
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            apply(v, $sformatf("vec%0d", i));
        end
        check("table_rise_pulses", rise_seen - r0, 2);
        check("table_fall_pulses", fall_seen - f0, 1);

        repeat (8) drive(1'b0, 1'b0);
        check("release_before_sat", A, 0);

        // Saturation: 260 rejected 2-cycle highs.
        r0 = rise_seen;
        for (int k = 0; k < 260; k++) begin
            drive(1'b1, 1'b0);
            if (k == 1 || k == 128 || k == 255 || k == 256)
                check($sformatf("glitch_sat_k%0d", k), glitch_cnt, (k > 255) ? 255 : k);
            drive(1'b1, 1'b0);
            drive(1'b0, 1'b0);
            drive(1'b0, 1'b0);
        end
        drive(1'b0, 1'b0);
        check("glitch_saturated", glitch_cnt, 255);
        check("sat_A_low", A, 0);
        check("sat_no_rise", rise_seen - r0, 0);

        // Clear coincides with the increment edge of another glitch.
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        check("clr_wins", glitch_cnt, 0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        check("glitch_after_clr", glitch_cnt, 1);

        // Mid-check reset while in RISE_CHK with cnt=2.
        repeat (4) drive(1'b1, 1'b0);
        check("midchk_cnt_before", dut.cnt_q, 2);
        Reset = 1'b0;
        #1;
        check("midchk_A", A, 0);
        check("midchk_a_rise", a_rise, 0);
        check("midchk_cnt", dut.cnt_q, 0);
        check("midchk_glitch", glitch_cnt, 0);
        #1;
        Reset = 1'b1;
        for (int i = 0; i < 7; i++) begin
            v.raw = 1'b1; v.clr = 1'b0; v.a = (i >= 5); v.rise = (i == 5); v.fall = 1'b0; v.g = 8'd0;
            apply(v, $sformatf("post_reset_rise%0d", i));
        end

        // Reset while HIGH: A drops at once, no a_fall ever seen.
        f0 = fall_seen;
        Reset = 1'b0;
        #1;
        check("rst_high_A", A, 0);
        check("rst_high_a_fall", a_fall, 0);
        key_raw = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        check("rst_high_A_held", A, 0);
        Reset = 1'b1;
        repeat (8) drive(1'b0, 1'b0);
        check("rst_high_A_after", A, 0);
        check("rst_high_no_fall", fall_seen - f0, 0);
        check("never_both_pulses", both_seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Input conditioner that turns a raw, asynchronous, bouncing push-button or contact signal into the clean level `A` consumed by the Idle/Start/Stop/Clear control FSM. It sits directly upstream of that FSM. It synchronises the raw input and debounces it with a four-state machine. It also produces one-cycle edge pulses and a saturating glitch counter for diagnostics.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth; must be ≥ 2.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable samples required to accept a level change; must be ≥ 2.
- `Clock`, input, 1: single clock; all state updates on its rising edge.
- `Reset`, input, 1: asynchronous, active-low reset.
- `key_raw`, input, 1: raw asynchronous contact input.
- `glitch_clr`, input, 1: synchronous clear of `glitch_cnt`.
- `A`, output, 1: debounced level; connects to the control FSM's `A` input.
- `a_rise`, output, 1: one-cycle pulse on accepted 0→1 change.
- `a_fall`, output, 1: one-cycle pulse on accepted 1→0 change.
- `glitch_cnt`, output, 8: count of rejected transitions; saturates at 255.

## Operation
- **Synchroniser:** `SYNC_STAGES` flops, all reset to 0. The last stage is `key_s`. The FSM only ever samples `key_s`.
- **Counter:** `cnt`, width `CNT_W = $clog2(DEBOUNCE_CYCLES)`, reset to 0.
- **States:** `LOW`, `RISE_CHK`, `HIGH`, `FALL_CHK`. Reset state is `LOW`.
- **LOW:**
  - `key_s`=1 → `RISE_CHK`, `cnt`←1.
  - Otherwise stay in `LOW`.
- **RISE_CHK:**
  - `key_s`=0 → `LOW`, `cnt`←0, glitch increment.
  - `key_s`=1 and `cnt`==`DEBOUNCE_CYCLES`−1 → `HIGH`, `cnt`←0, `A`←1, `a_rise`←1.
  - Otherwise `cnt`←`cnt`+1.
- **HIGH:**
  - `key_s`=0 → `FALL_CHK`, `cnt`←1.
  - Otherwise stay in `HIGH`.
- **FALL_CHK:** mirror of `RISE_CHK`.
  - `key_s`=1 → `HIGH`, glitch increment.
  - `key_s`=0 and `cnt`==`DEBOUNCE_CYCLES`−1 → `LOW`, `A`←0, `a_fall`←1.
- **Level hold:** `A` is unchanged in the check states. A rejected bounce never toggles `A`.
- **`glitch_cnt`:** +1 per glitch increment and saturates at 255, never wrapping. If `glitch_clr` and an increment occur in the same cycle, clear wins and the result is 0.
- **Reset values:** all outputs, `cnt` and every synchroniser stage are 0 on reset.

## Timing
- **Registered outputs:** all outputs are registers with no combinational path from inputs.
- **Acceptance latency:** let edge e0 be the first rising edge at which `key_raw`=1 is captured. `A` goes high after edge e0 + `SYNC_STAGES` + `DEBOUNCE_CYCLES` − 1, provided `key_raw` is held. With defaults 2/16 this is 17 edges. Release latency is identical.
- **Edge pulses:** `a_rise`/`a_fall` are high for exactly one cycle, coincident with the first cycle of the new `A` value. They are never both high.
- **Minimum stable width:** a change shorter than `DEBOUNCE_CYCLES` consecutive `key_s` samples is rejected.
- **Back-to-back edges:** accepted changes in opposite directions are at least `DEBOUNCE_CYCLES` cycles apart.
- **Reset mid-check:** asynchronous `Reset` low forces `LOW`, `A`=0 and pulses 0 immediately. Partial counts are discarded, and no `a_fall` is emitted when reset occurs in `HIGH`.
- **Raw input at release:** if `key_raw` is 1 while `Reset` is released, it is treated as a fresh rising change with full latency.

## Structure
- **Package `key_cond_pkg`:**
  - 2-bit state encoding: `LOW`=00, `RISE_CHK`=01, `HIGH`=10, `FALL_CHK`=11.
  - `GLITCH_W`=8 and `GLITCH_MAX`=255.
- **Sub-module `bit_sync`:** parameterised by stage count, with async active-low reset. It is reusable for other asynchronous inputs to the control FSM.
- **Top level:** `key_conditioner` holds the FSM, the debounce counter and the glitch counter.
- **Elaboration checks:** parameter checks for `SYNC_STAGES` ≥ 2 and `DEBOUNCE_CYCLES` ≥ 2.

## Test plan
Bench parameters are `SYNC_STAGES`=2 and `DEBOUNCE_CYCLES`=4.

- **Clean press:** `key_raw` 0→1 held → `A`=1 and `a_rise`=1 for one cycle after edge e0+5; `glitch_cnt`=0.
- **Bounce:** `key_raw` high 3 cycles, low 2, high held → one rejection, `glitch_cnt`=1; `A` rises 5 edges after the final rise, with exactly one `a_rise`.
- **Release:** from `HIGH`, `key_raw` →0 held → `A`=0 with a single `a_fall` pulse 5 edges later; `a_rise` stays 0 throughout.
- **Saturation and clear:** 260 rejected 2-cycle glitches → `glitch_cnt`=255 with no wrap. `glitch_clr` asserted in the same cycle as a glitch increment → 0.
- **Mid-check reset:** `Reset` pulsed low while in `RISE_CHK` with `cnt`=2 → immediate `A`=0 and `cnt`=0. After release with `key_raw` still 1, `A` rises after the full 5-edge latency.
- **Reset in HIGH:** `Reset` asserted while `A`=1 → `A`=0 asynchronously with no `a_fall` pulse observed.
